store_lane_buffer: RTL and testbench

- Store-side counterpart of the immediate/load extension path in the pipelined CPU.
- Takes a 32-bit register value from the MEM stage and narrows it to a byte, halfword or word write, with byte-lane enables and lane-replicated data.
- Queues accepted stores in a small FIFO and drains them to data memory over a req/ack handshake.
- Flags misaligned or illegal stores instead of issuing them.

---
 rtl/store_lane_buffer.sv | 77 +++++++
 tb/tb_store_lane_buffer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/store_lane_buffer.sv
// store_lane_buffer: narrows MEM-stage stores to byte lanes, queues them and drains to data memory
module store_lane_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [AW-1:0]            st_addr,
  input  logic [31:0]              st_data,
  input  logic [1:0]               st_size,
  output logic                     mem_req,
  input  logic                     mem_ack,
  output logic [AW-3:0]            mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  output logic                     misalign_exc,
  output logic [AW-1:0]            misalign_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-3:0] q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [3:0]    q_be   [DEPTH];
  logic [PW-1:0] wp, rp, hp;
  logic [1:0]    off;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic          legal, acc, push, pop, load;
  assign off   = st_addr[1:0];
  assign wdata = st_size == 2'b10 ? {4{st_data[7:0]}} : st_size == 2'b01 ? {2{st_data[15:0]}} : st_data;
  assign be    = st_size == 2'b10 ? 4'b0001 << off : st_size == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign legal = st_size == 2'b10 || (st_size == 2'b01 && !off[0]) || (st_size == 2'b00 && off == 2'b00);
  assign st_ready = count < CW'(DEPTH);
  assign acc   = st_valid && st_ready;
  assign push  = acc && legal;
  assign pop   = mem_req && mem_ack;
  // the head stays queued while requested; after a pop the next head is rp+1
  assign hp    = rp + PW'(pop);
  assign load  = (!mem_req || pop) && (count > CW'(pop));
  assign empty = count == '0 && !mem_req;
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wp] <= st_addr[AW-1:2];
      q_data[wp] <= wdata;
      q_be[wp]   <= be;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp            <= '0;
      rp            <= '0;
      count         <= '0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      count        <= count + CW'(push) - CW'(pop);
      misalign_exc <= acc && !legal;
      if (acc && !legal) misalign_addr <= st_addr;
      if (load) begin
        mem_req   <= 1'b1;
        mem_addr  <= q_addr[hp];
        mem_wdata <= q_data[hp];
        mem_be    <= q_be[hp];
      end else if (pop) mem_req <= 1'b0;
    end
  end
endmodule

// File: tb/tb_store_lane_buffer.sv
// tb_store_lane_buffer: directed checks of lane formation, rejection, queueing, drain order and async reset
module tb_store_lane_buffer;
  logic        clk = 0, rst_n = 0;
  logic        st_valid = 0, st_ready, mem_req, mem_ack = 0;
  logic [31:0] st_addr = 0, st_data = 0, mem_wdata, misalign_addr;
  logic [1:0]  st_size = 0;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic        misalign_exc, empty;
  logic [2:0]  count;
  int          n_chk = 0, n_fail = 0;

  store_lane_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .misalign_exc(misalign_exc),
    .misalign_addr(misalign_addr), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = v; st_addr = a; st_data = d; st_size = s;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    tick();
    chk("rst_req", mem_req, 0);
    chk("rst_ready", st_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_exc", misalign_exc, 0);
    chk("rst_maddr", misalign_addr, 0);
    chk("rst_be", mem_be, 0);
    rst_n = 1;
    tick();
    // byte store, top lane
    drive(1, 32'h0000_1003, 32'h1234_56AB, 2'b10); tick(); drive(0, 0, 0, 0);
    chk("b_count", count, 1);
    chk("b_req_lat", mem_req, 0);
    tick();
    chk("b_req", mem_req, 1);
    chk("b_addr", mem_addr, 30'h400);
    chk("b_wdata", mem_wdata, 32'hABAB_ABAB);
    chk("b_be", mem_be, 4'b1000);
    mem_ack = 1; tick(); mem_ack = 0;
    chk("b_done_req", mem_req, 0);
    chk("b_empty", empty, 1);
    chk("b_hold_be", mem_be, 4'b1000);
    // halfword upper lanes, then aligned word
    drive(1, 32'h0000_0002, 32'hDEAD_BEEF, 2'b01); tick(); drive(0, 0, 0, 0); tick();
    chk("h_req", mem_req, 1);
    chk("h_wdata", mem_wdata, 32'hBEEF_BEEF);
    chk("h_be", mem_be, 4'b1100);
    chk("h_addr", mem_addr, 30'h0);
    mem_ack = 1; tick(); mem_ack = 0;
    drive(1, 32'h0000_0010, 32'hCAFE_F00D, 2'b00); tick(); drive(0, 0, 0, 0); tick();
    chk("w_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("w_be", mem_be, 4'b1111);
    chk("w_addr", mem_addr, 30'h4);
    mem_ack = 1; tick(); mem_ack = 0;
    chk("w_empty", empty, 1);
    // misaligned word then reserved size, back to back
    drive(1, 32'h0000_0006, 32'h1111_1111, 2'b00); tick();
    chk("x1_exc", misalign_exc, 1);
    chk("x1_addr", misalign_addr, 32'h6);
    chk("x1_count", count, 0);
    drive(1, 32'h0000_0008, 32'h2222_2222, 2'b11); tick(); drive(0, 0, 0, 0);
    chk("x2_exc", misalign_exc, 1);
    chk("x2_addr", misalign_addr, 32'h8);
    tick();
    chk("x_exc_end", misalign_exc, 0);
    chk("x_req", mem_req, 0);
    chk("x_count", count, 0);
    chk("x_addr_hold", misalign_addr, 32'h8);
    // fill to full with ack held low
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 2'b00); tick();
    end
    chk("f_count", count, 4);
    chk("f_ready", st_ready, 0);
    chk("f_addr", mem_addr, 30'h40);
    drive(1, 32'h110, 32'hA4, 2'b00); tick();
    chk("f_blocked", count, 4);
    chk("f_stable_addr", mem_addr, 30'h40);
    chk("f_stable_data", mem_wdata, 32'hA0);
    // drain in order, fifth store enters as pointers wrap
    mem_ack = 1; tick();
    chk("d1_count", count, 3);
    chk("d1_ready", st_ready, 1);
    chk("d1_addr", mem_addr, 30'h41);
    chk("d1_data", mem_wdata, 32'hA1);
    tick(); drive(0, 0, 0, 0);
    chk("d2_count", count, 3);
    chk("d2_addr", mem_addr, 30'h42);
    tick();
    chk("d3_count", count, 2);
    chk("d3_addr", mem_addr, 30'h43);
    tick();
    chk("d4_count", count, 1);
    chk("d4_addr", mem_addr, 30'h44);
    chk("d4_data", mem_wdata, 32'hA4);
    tick();
    chk("d5_req", mem_req, 0);
    chk("d5_empty", empty, 1);
    // async reset mid-drain
    mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h200 + 32'(4 * i), 32'hB0 + 32'(i), 2'b00); tick();
    end
    drive(0, 0, 0, 0);
    chk("r_pre_count", count, 3);
    chk("r_pre_req", mem_req, 1);
    #2 rst_n = 0;
    #1;
    chk("r_req", mem_req, 0);
    chk("r_count", count, 0);
    chk("r_be", mem_be, 0);
    chk("r_wdata", mem_wdata, 0);
    chk("r_empty", empty, 1);
    tick(); rst_n = 1; mem_ack = 1;
    tick(); tick(); tick();
    chk("r_idle_req", mem_req, 0);
    drive(1, 32'h0000_0301, 32'h0000_0077, 2'b10); tick(); drive(0, 0, 0, 0); tick();
    chk("n_req", mem_req, 1);
    chk("n_be", mem_be, 4'b0010);
    chk("n_wdata", mem_wdata, 32'h7777_7777);
    chk("n_addr", mem_addr, 30'hC0);
    tick();
    chk("n_empty", empty, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
